// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_unit_if : ID/EX hazard inputs and pipeline control outputs    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic             ID_Valid;
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic [4:0]       EX_Rw;
    logic             EX_BranchTaken;
    logic             ExtStall_Req;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IF_Flush;
    logic             ID_Bubble;
    logic             Pipe_Freeze;
    logic             ExtStall_Ack;
    logic             StallErr;
    logic [CNT_W-1:0] LoadStallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
               EX_MemRead, EX_Rw, EX_BranchTaken, ExtStall_Req,
        input  PCWrite, IFIDWrite, IF_Flush, ID_Bubble, Pipe_Freeze,
               ExtStall_Ack, StallErr, LoadStallCnt, FlushCnt
    );

    modport slave (
        input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
               EX_MemRead, EX_Rw, EX_BranchTaken, ExtStall_Req,
        output PCWrite, IFIDWrite, IF_Flush, ID_Bubble, Pipe_Freeze,
               ExtStall_Ack, StallErr, LoadStallCnt, FlushCnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_stall_unit : load-use / branch / external-freeze pipeline control   |
// | Optional perf counters: HAZARD_PERF_CNT_EN.  Rev 1.0                       |
// +----------------------------------------------------------------------------+
module hazard_stall_unit #(
    parameter int MAX_STALL = 64,
    parameter int CNT_W     = 16
) (
    input  wire logic          CLK,
    input  wire logic          Reset_L,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    localparam int                c_WD_W   = $clog2(MAX_STALL + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(MAX_STALL);

    state_t            r_state;
    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_ack;
    logic              r_err;

    logic w_load_use;
    logic w_freeze;
    logic w_branch;
    logic w_stall;
    logic w_pc_write;

    always_comb begin
        w_load_use = hz.ID_Valid && hz.EX_MemRead && (hz.EX_Rw != 5'd0) &&
                     ((hz.ID_UsesRs && (hz.ID_Rs == hz.EX_Rw)) ||
                      (hz.ID_UsesRt && (hz.ID_Rt == hz.EX_Rw)));
        w_freeze   = hz.ExtStall_Req;
        // EX holds a bubble outside RUN, so only RUN can react to branch/LU
        w_branch   = !w_freeze && (r_state == RUN) && hz.EX_BranchTaken;
        w_stall    = !w_freeze && (r_state == RUN) && !hz.EX_BranchTaken && w_load_use;
        w_pc_write = !w_freeze && !w_stall;
    end

    assign hz.PCWrite      = Reset_L && w_pc_write;
    assign hz.IFIDWrite    = Reset_L && w_pc_write;
    assign hz.IF_Flush     = Reset_L && w_branch;
    assign hz.ID_Bubble    = !Reset_L || w_branch || w_stall;
    assign hz.Pipe_Freeze  = Reset_L && w_freeze;
    assign hz.ExtStall_Ack = r_ack;
    assign hz.StallErr     = r_err;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state  <= RUN;
            r_wd_cnt <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ack <= hz.ExtStall_Req;
            if (!w_freeze) begin
                if (w_branch)     r_state <= FLUSH;
                else if (w_stall) r_state <= LOAD_STALL;
                else              r_state <= RUN;
            end
            if (w_pc_write) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != c_WD_MAX) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
                if (r_wd_cnt == c_WD_MAX - 1'b1) r_err <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // w_stall / w_branch already exclude frozen cycles, so counters hold then
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_load_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_load_cnt != {CNT_W{1'b1}}))
                r_load_cnt <= r_load_cnt + 1'b1;
            if (w_branch && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign hz.LoadStallCnt = r_load_cnt;
    assign hz.FlushCnt     = r_flush_cnt;
`else
    assign hz.LoadStallCnt = '0;
    assign hz.FlushCnt     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_stall_unit : directed stimulus, per-cycle model compare          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_hazard_stall_unit;
    localparam int MAX_STALL = 64;
    localparam int CNT_W     = 16;
`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) hz ();

    hazard_stall_unit #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .CLK     (clk),
        .Reset_L (rst_n),
        .hz      (hz.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "EX holds a bubble" means last unfrozen cycle inserted a stall or squash
    bit m_ex_bubble = 0;
    int m_run = 0;
    bit m_err = 0;
    bit m_ack = 0;
    int m_ls = 0;
    int m_fl = 0;

    always @(negedge clk) begin
        bit lu, frz, br, st, pcw;
        int cmax;
        cmax = (1 << CNT_W) - 1;
        if (!rst_n) begin
            chk("rst_pcw", hz.PCWrite, 0);     chk("rst_ifidw", hz.IFIDWrite, 0);
            chk("rst_flush", hz.IF_Flush, 0);  chk("rst_bubble", hz.ID_Bubble, 1);
            chk("rst_frz", hz.Pipe_Freeze, 0); chk("rst_ack", hz.ExtStall_Ack, 0);
            chk("rst_err", hz.StallErr, 0);
            chk("rst_lscnt", hz.LoadStallCnt, 0); chk("rst_flcnt", hz.FlushCnt, 0);
            m_ex_bubble = 0; m_run = 0; m_err = 0; m_ack = 0; m_ls = 0; m_fl = 0;
        end else begin
            lu  = hz.ID_Valid && hz.EX_MemRead && hz.EX_Rw != 0 &&
                  ((hz.ID_UsesRs && hz.ID_Rs == hz.EX_Rw) || (hz.ID_UsesRt && hz.ID_Rt == hz.EX_Rw));
            frz = hz.ExtStall_Req;
            br  = !frz && !m_ex_bubble && hz.EX_BranchTaken;
            st  = !frz && !m_ex_bubble && !hz.EX_BranchTaken && lu;
            pcw = !frz && !st;
            chk("pcw", hz.PCWrite, 32'(pcw));
            chk("ifidw", hz.IFIDWrite, 32'(pcw));
            chk("flush", hz.IF_Flush, 32'(br));
            chk("bubble", hz.ID_Bubble, 32'(br || st));
            chk("freeze", hz.Pipe_Freeze, 32'(frz));
            chk("ack", hz.ExtStall_Ack, 32'(m_ack));
            chk("err", hz.StallErr, 32'(m_err));
            chk("lscnt", hz.LoadStallCnt, PERF ? 32'(m_ls) : 0);
            chk("flcnt", hz.FlushCnt, PERF ? 32'(m_fl) : 0);
            m_ack = frz;
            if (!frz) begin
                m_ex_bubble = br || st;
                if (st && m_ls < cmax) m_ls++;
                if (br && m_fl < cmax) m_fl++;
            end
            if (pcw) m_run = 0;
            else if (m_run < MAX_STALL) begin
                m_run++;
                if (m_run == MAX_STALL) m_err = 1;
            end
        end
    end

    task automatic idle();
        hz.ID_Valid = 0; hz.ID_Rs = 0; hz.ID_Rt = 0; hz.ID_UsesRs = 0; hz.ID_UsesRt = 0;
        hz.EX_MemRead = 0; hz.EX_Rw = 0; hz.EX_BranchTaken = 0; hz.ExtStall_Req = 0;
    endtask

    task automatic lw_use(input logic [4:0] rw, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt);
        hz.ID_Valid = 1; hz.ID_Rs = rs; hz.ID_Rt = rt; hz.ID_UsesRs = urs; hz.ID_UsesRt = urt;
        hz.EX_MemRead = 1; hz.EX_Rw = rw;
    endtask

    task automatic mid(); @(negedge clk); #1; endtask
    task automatic nxt(); @(posedge clk); #1; endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("lit_rst_pcw", hz.PCWrite, 0);
        chk("lit_rst_bubble", hz.ID_Bubble, 1);
        nxt(); rst_n = 1;
        mid(); chk("lit_run_pcw", hz.PCWrite, 1);
        nxt();

        // lw $5 followed by a reader of rs=5: one stall cycle
        lw_use(5, 5, 0, 1, 0);
        mid(); chk("lit_lu_pcw", hz.PCWrite, 0); chk("lit_lu_ifidw", hz.IFIDWrite, 0);
        chk("lit_lu_bubble", hz.ID_Bubble, 1);
        nxt();
        mid(); chk("lit_ls_pcw", hz.PCWrite, 1); chk("lit_ls_bubble", hz.ID_Bubble, 0);
        chk("lit_lscnt1", hz.LoadStallCnt, PERF ? 1 : 0);
        nxt(); idle();

        lw_use(0, 0, 0, 1, 1);
        mid(); chk("lit_rw0_pcw", hz.PCWrite, 1); nxt();
        lw_use(5, 3, 5, 1, 0);
        mid(); chk("lit_nort_pcw", hz.PCWrite, 1); nxt();
        lw_use(7, 1, 7, 0, 1);
        mid(); chk("lit_rt_pcw", hz.PCWrite, 0); nxt();
        mid(); chk("lit_rt_after", hz.PCWrite, 1); nxt();
        lw_use(7, 7, 7, 1, 1); hz.ID_Valid = 0;
        mid(); chk("lit_novalid_pcw", hz.PCWrite, 1); nxt();

        // taken branch beats load-use; FLUSH ignores a second taken branch
        lw_use(9, 9, 0, 1, 0); hz.EX_BranchTaken = 1;
        mid(); chk("lit_br_flush", hz.IF_Flush, 1); chk("lit_br_bubble", hz.ID_Bubble, 1);
        chk("lit_br_pcw", hz.PCWrite, 1);
        nxt();
        mid(); chk("lit_fl_flush", hz.IF_Flush, 0); chk("lit_fl_pcw", hz.PCWrite, 1);
        chk("lit_flcnt1", hz.FlushCnt, PERF ? 1 : 0);
        nxt(); idle();

        // three-cycle freeze while in LOAD_STALL
        lw_use(4, 4, 0, 1, 0);
        mid(); chk("lit_fz_lu", hz.PCWrite, 0); nxt();
        hz.ExtStall_Req = 1;
        mid(); chk("lit_fz1_frz", hz.Pipe_Freeze, 1); chk("lit_fz1_ack", hz.ExtStall_Ack, 0);
        chk("lit_fz1_bubble", hz.ID_Bubble, 0); nxt();
        mid(); chk("lit_fz2_ack", hz.ExtStall_Ack, 1); nxt();
        mid(); chk("lit_fz3_frz", hz.Pipe_Freeze, 1); nxt();
        hz.ExtStall_Req = 0;
        mid(); chk("lit_fz4_ack", hz.ExtStall_Ack, 1); chk("lit_fz4_pcw", hz.PCWrite, 1);
        chk("lit_fz4_frz", hz.Pipe_Freeze, 0); nxt();
        mid(); chk("lit_fz5_ack", hz.ExtStall_Ack, 0); chk("lit_fz5_pcw", hz.PCWrite, 0); nxt();
        idle();
        mid(); chk("lit_fz6_pcw", hz.PCWrite, 1); nxt();

        // single-cycle request pulse
        hz.ExtStall_Req = 1;
        mid(); chk("lit_pl_frz", hz.Pipe_Freeze, 1); nxt();
        hz.ExtStall_Req = 0;
        mid(); chk("lit_pl_ack1", hz.ExtStall_Ack, 1); nxt();
        mid(); chk("lit_pl_ack0", hz.ExtStall_Ack, 0); nxt();

        // watchdog: MAX_STALL consecutive frozen cycles
        hz.ExtStall_Req = 1;
        for (int i = 1; i <= MAX_STALL; i++) begin
            mid();
            if (i == MAX_STALL) chk("lit_wd_before", hz.StallErr, 0);
            nxt();
        end
        hz.ExtStall_Req = 0;
        mid(); chk("lit_wd_set", hz.StallErr, 1); nxt();
        repeat (3) nxt();
        mid(); chk("lit_wd_sticky", hz.StallErr, 1); nxt();

        // reset while in FLUSH
        hz.EX_BranchTaken = 1;
        mid(); chk("lit_rf_flush", hz.IF_Flush, 1); nxt();
        idle(); rst_n = 0;
        #1;
        chk("lit_rf_pcw", hz.PCWrite, 0); chk("lit_rf_bubble", hz.ID_Bubble, 1);
        chk("lit_rf_err", hz.StallErr, 0); chk("lit_rf_flcnt", hz.FlushCnt, 0);
        mid(); nxt(); rst_n = 1;
        hz.EX_BranchTaken = 1;
        mid(); chk("lit_rel_pcw", hz.PCWrite, 1); chk("lit_rel_flush", hz.IF_Flush, 1);
        chk("lit_rel_lscnt", hz.LoadStallCnt, 0);
        nxt(); idle();
        repeat (2) nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side partner of the forwarding unit in the 5-stage MIPS pipeline.
- Detects hazards that forwarding cannot resolve: load-use, taken-branch redirect, and external memory stall.
- Drives PC/IF-ID write enables, IF-ID flush, ID-EX bubble insertion and global pipeline freeze.
- Sits between the ID and EX stage registers, alongside the forwarding unit.

Parameters:
- MAX_STALL, 64: count of consecutive PC-frozen cycles at which the watchdog error fires (≥2).
- CNT_W, 16: width of the optional performance counters.

Ports:
- CLK  input  1  system clock, rising edge
- Reset_L  input  1  asynchronous active-low reset
- ID_Valid  input  1  ID stage holds a real instruction
- ID_Rs  input  5  source register rs of the ID instruction
- ID_Rt  input  5  source register rt of the ID instruction
- ID_UsesRs  input  1  ID instruction reads rs
- ID_UsesRt  input  1  ID instruction reads rt (includes store data)
- EX_MemRead  input  1  EX instruction is a load
- EX_Rw  input  5  destination register of the EX instruction
- EX_BranchTaken  input  1  EX branch/jump resolved taken this cycle
- ExtStall_Req  input  1  memory-side freeze request, level
- PCWrite  output  1  PC load enable
- IFIDWrite  output  1  IF/ID register load enable
- IF_Flush  output  1  zero the IF/ID instruction on the next edge
- ID_Bubble  output  1  zero the ID/EX control bits on the next edge
- Pipe_Freeze  output  1  hold the ID/EX, EX/MEM and MEM/WB registers
- ExtStall_Ack  output  1  registered acknowledge of ExtStall_Req
- StallErr  output  1  sticky watchdog error
- LoadStallCnt  output  CNT_W  load-use stall count (optional feature only)
- FlushCnt  output  CNT_W  branch flush count (optional feature only)

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (Reset_L). All state clears immediately when Reset_L=0.
- During reset: PCWrite=0, IFIDWrite=0, IF_Flush=0, ID_Bubble=1, Pipe_Freeze=0, ExtStall_Ack=0, StallErr=0, counters=0, state=RUN.
- FSM states:
  - RUN=0
  - LOAD_STALL=1
  - FLUSH=2
- Control outputs are combinational from state and inputs. State, Ack, the watchdog and the counters are registered.
- Load-use detect (LU) is true when all hold:
  - ID_Valid=1, EX_MemRead=1 and EX_Rw≠0
  - and either (ID_UsesRs=1 and ID_Rs==EX_Rw) or (ID_UsesRt=1 and ID_Rt==EX_Rw)
- Per-cycle priority, highest first:
  1. ExtStall_Req=1, any state:
     - Pipe_Freeze=1, PCWrite=0, IFIDWrite=0, IF_Flush=0, ID_Bubble=0.
     - FSM state and perf counters hold.
     - The watchdog increments.
  2. State RUN and EX_BranchTaken=1:
     - PCWrite=1, IFIDWrite=1, IF_Flush=1, ID_Bubble=1. LU is ignored.
     - Next state FLUSH.
  3. State RUN and LU=1:
     - PCWrite=0, IFIDWrite=0, ID_Bubble=1, IF_Flush=0.
     - Next state LOAD_STALL.
  4. Otherwise:
     - PCWrite=1, IFIDWrite=1, IF_Flush=0, ID_Bubble=0, Pipe_Freeze=0.
     - Next state RUN.
- LOAD_STALL and FLUSH:
  - EX holds a bubble in these states, so EX_BranchTaken and LU are ignored.
  - Outputs are as in item 4; next state is RUN unless frozen.
- Load-use penalty is exactly 1 cycle. Branch penalty is exactly 2 squashed instructions (IF and ID).
- ExtStall_Ack is ExtStall_Req registered: it rises one cycle after Req and falls one cycle after Req drops.
  - The requester holds Req until it sees Ack.
  - A one-cycle Req pulse still freezes that cycle and yields a one-cycle Ack.
- Watchdog:
  - Counter increments on every cycle with PCWrite=0 and clears on any cycle with PCWrite=1.
  - It saturates at MAX_STALL.
  - On reaching MAX_STALL, StallErr sets and stays set until reset.
- Reset mid-stall or mid-flush returns to RUN with reset outputs. No flush or stall carries over.

Optional Feature:
HAZARD_PERF_CNT_EN
- When defined:
  - LoadStallCnt increments on each entry to LOAD_STALL.
  - FlushCnt increments on each entry to FLUSH.
  - Both saturate at all-ones, are frozen while ExtStall_Req=1, and clear on reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- lw $5 in EX (EX_MemRead=1, EX_Rw=5), ID add reads Rs=5 → one cycle with PCWrite=0, IFIDWrite=0, ID_Bubble=1, then state LOAD_STALL, then normal. LoadStallCnt=1.
- Same as above with EX_Rw=0, or with ID_UsesRt=0 and ID_Rt=5 → no stall; PCWrite stays 1.
- EX_BranchTaken=1 together with LU=1 → IF_Flush=1, ID_Bubble=1, PCWrite=1, no stall. Next cycle state FLUSH, where EX_BranchTaken=1 is ignored. FlushCnt=1.
- ExtStall_Req high 3 cycles during LOAD_STALL → Pipe_Freeze=1 for 3 cycles, Ack high cycles 2–4, state still LOAD_STALL afterwards, then RUN.
- ExtStall_Req held 64 cycles with MAX_STALL=64 → StallErr=1 at cycle 64 and stays 1 after Req drops, until Reset_L=0.
- Reset_L asserted during FLUSH → outputs immediately take reset values. After release: state RUN, PCWrite=1, counters=0.
